bios_loader: RTL

BIOS_LOADER -- requirements
Module: bios_loader

---
 rtl/bios_loader_pkg.sv | 55 +++++
 rtl/bios_loader_keyword_rom.sv | 33 +++
 rtl/bios_loader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/bios_loader_pkg.sv
// Shared types for the BIOS loader: command encoding, loader state enum,
// ASCII constants and the keyword/response tables built from them.
package bios_loader_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        CMD_RST   = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_BOOT  = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_KEYWORD = 3'd1,
        ST_SIZE    = 3'd2,
        ST_ADDR    = 3'd3,
        ST_SRC_RD  = 3'd4,
        ST_SRC_TX  = 3'd5,
        ST_RESP    = 3'd6,
        ST_FINISH  = 3'd7
    } state_e;

    localparam logic [7:0] ASCII_UC_B = 8'h42;
    localparam logic [7:0] ASCII_UC_N = 8'h4E;
    localparam logic [7:0] ASCII_UC_R = 8'h52;
    localparam logic [7:0] ASCII_B    = 8'h62;
    localparam logic [7:0] ASCII_E    = 8'h65;
    localparam logic [7:0] ASCII_I    = 8'h69;
    localparam logic [7:0] ASCII_N    = 8'h6E;
    localparam logic [7:0] ASCII_O    = 8'h6F;
    localparam logic [7:0] ASCII_P    = 8'h70;
    localparam logic [7:0] ASCII_R    = 8'h72;
    localparam logic [7:0] ASCII_S    = 8'h73;
    localparam logic [7:0] ASCII_T    = 8'h74;
    localparam logic [7:0] ASCII_W    = 8'h77;

    // Keywords packed first-character-in-LSB so byte n is kw[8*n +: 8].
    localparam logic [39:0] KW_NOP   = {8'h00, 8'h00, ASCII_P, ASCII_O, ASCII_N};
    localparam logic [39:0] KW_RST   = {8'h00, 8'h00, ASCII_T, ASCII_S, ASCII_R};
    localparam logic [39:0] KW_WRITE = {ASCII_E, ASCII_T, ASCII_I, ASCII_R, ASCII_W};
    localparam logic [39:0] KW_BOOT  = {8'h00, ASCII_T, ASCII_O, ASCII_O, ASCII_B};

    function automatic logic [7:0] expected_resp(input cmd_e cmd);
        logic [7:0] r;
        r = 8'h00;
        case (cmd)
            CMD_NOP:  r = ASCII_UC_N;
            CMD_RST:  r = ASCII_UC_R;
            CMD_BOOT: r = ASCII_UC_B;
            default:  r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bios_loader_keyword_rom.sv
// Maps (command, byte index) to the keyword byte sent to the BIOS and the
// keyword length; indices past the end read as 8'h00.
module bios_loader_keyword_rom
    import bios_loader_pkg::*;
(
    input  cmd_e       cmd_i,
    input  logic [2:0] idx_i,
    output logic [7:0] byte_o,
    output logic [2:0] len_o
);

    logic [39:0] kw;

    always_comb begin
        kw    = KW_NOP;
        len_o = 3'd3;
        case (cmd_i)
            CMD_NOP:   begin kw = KW_NOP;   len_o = 3'd3; end
            CMD_RST:   begin kw = KW_RST;   len_o = 3'd3; end
            CMD_WRITE: begin kw = KW_WRITE; len_o = 3'd5; end
            CMD_BOOT:  begin kw = KW_BOOT;  len_o = 3'd4; end
            default:   begin kw = KW_NOP;   len_o = 3'd3; end
        endcase
    end

    always_comb begin
        byte_o = 8'h00;
        if (idx_i < 3'd5) begin
            byte_o = kw[{idx_i, 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/bios_loader.sv
// BIOS loader: sends a keyword (plus size/address/image for WRITE) to the
// BIOS and checks its one-byte reply. Optional reply timeout: BIOS_LOADER_TIMEOUT_EN.
module bios_loader
    import bios_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned RESP_TIMEOUT = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  i_start,
    input  logic [1:0]            i_cmd,
    input  logic [31:0]           i_size,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [ADDR_WIDTH-1:0] i_src_base,
    output logic                  o_src_req,
    output logic [ADDR_WIDTH-1:0] o_src_addr,
    input  logic [7:0]            i_src_data,
    output logic [7:0]            o_data,
    output logic                  o_valid,
    input  logic                  i_out_ready,
    input  logic [7:0]            i_data,
    input  logic                  i_valid,
    output logic                  o_in_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [7:0]            o_resp,
    output state_e                o_state
);

    state_e                state_q, state_d;
    cmd_e                  cmd_q, cmd_d;
    logic [31:0]           size_q, size_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [2:0]            idx_q, idx_d;
    logic [7:0]            data_q, data_d;
    logic [7:0]            resp_q, resp_d;
    logic                  err_q, err_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [7:0]            kw_byte;
    logic [2:0]            kw_len;
    logic [31:0]           addr32;
    logic                  xfer;
`ifdef BIOS_LOADER_TIMEOUT_EN
    logic [31:0]           tmo_q, tmo_d;
`endif

    bios_loader_keyword_rom u_rom (
        .cmd_i  (cmd_q),
        .idx_i  (idx_q),
        .byte_o (kw_byte),
        .len_o  (kw_len)
    );

    assign addr32 = 32'(addr_q);

    // Both streams: a byte moves only on an enabled edge with valid and ready
    // both high; o_data is a function of held state, so it cannot move during a stall.
    always_comb begin
        o_valid = 1'b0;
        o_data  = 8'h00;
        case (state_q)
            ST_KEYWORD: begin o_valid = 1'b1; o_data = kw_byte; end
            ST_SIZE:    begin o_valid = 1'b1; o_data = size_q[{idx_q[1:0], 3'b000} +: 8]; end
            ST_ADDR:    begin o_valid = 1'b1; o_data = addr32[{idx_q[1:0], 3'b000} +: 8]; end
            ST_SRC_TX:  begin o_valid = 1'b1; o_data = data_q; end
            default:    begin o_valid = 1'b0; o_data = 8'h00; end
        endcase
    end

    assign xfer       = o_valid & i_out_ready;
    assign o_in_ready = (state_q == ST_RESP);
    assign o_src_req  = (state_q == ST_SRC_RD) & ~rd_pend_q;
    assign o_src_addr = src_q + ADDR_WIDTH'(cnt_q);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = (state_q == ST_FINISH);
    assign o_error    = err_q;
    assign o_resp     = resp_q;
    assign o_state    = state_q;

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        size_d    = size_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        src_d     = src_q;
        idx_d     = idx_q;
        data_d    = data_q;
        resp_d    = resp_q;
        err_d     = err_q;
        rd_pend_d = rd_pend_q;
`ifdef BIOS_LOADER_TIMEOUT_EN
        tmo_d     = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    cmd_d   = cmd_e'(i_cmd);
                    size_d  = i_size;
                    addr_d  = i_addr;
                    src_d   = i_src_base;
                    idx_d   = 3'd0;
                    cnt_d   = 32'd0;
                    state_d = ST_KEYWORD;
                end
            end
            ST_KEYWORD: begin
                if (xfer) begin
                    if (idx_q == kw_len - 3'd1) begin
                        idx_d   = 3'd0;
                        state_d = (cmd_q == CMD_WRITE) ? ST_SIZE : ST_RESP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_SIZE: begin
                if (xfer) begin
                    if (idx_q == 3'd3) begin
                        idx_d   = 3'd0;
                        state_d = ST_ADDR;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_ADDR: begin
                if (xfer) begin
                    if (idx_q == 3'd3) begin
                        idx_d   = 3'd0;
                        cnt_d   = 32'd0;
                        state_d = (size_q == 32'd0) ? ST_FINISH : ST_SRC_RD;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_SRC_RD: begin
                // First cycle issues the request, second captures the returned byte.
                if (!rd_pend_q) begin
                    rd_pend_d = 1'b1;
                end else begin
                    rd_pend_d = 1'b0;
                    data_d    = i_src_data;
                    state_d   = ST_SRC_TX;
                end
            end
            ST_SRC_TX: begin
                if (xfer) begin
                    cnt_d   = cnt_q + 32'd1;
                    state_d = (cnt_q + 32'd1 == size_q) ? ST_FINISH : ST_SRC_RD;
                end
            end
            ST_RESP: begin
                if (i_valid) begin
                    resp_d  = i_data;
                    err_d   = (i_data != expected_resp(cmd_q));
                    state_d = ST_FINISH;
                end
`ifdef BIOS_LOADER_TIMEOUT_EN
                else if (tmo_q == RESP_TIMEOUT - 1) begin
                    resp_d  = 8'h00;
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
`endif
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cmd_q     <= CMD_NOP;
            size_q    <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            src_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            resp_q    <= '0;
            err_q     <= 1'b0;
            rd_pend_q <= 1'b0;
        end else if (clk_en) begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            size_q    <= size_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            src_q     <= src_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            resp_q    <= resp_d;
            err_q     <= err_d;
            rd_pend_q <= rd_pend_d;
        end
    end

`ifdef BIOS_LOADER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else if (clk_en) begin
            tmo_q <= tmo_d;
        end
    end
`endif

endmodule
